// File: rtl/clk_time_set_ctrl.sv
// Button conditioning and time-set editor for the real-time clock.
// Debounced mode/inc/dec presses step an edit FSM that drives shadow set_* values and a load strobe.
module clk_time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOURS_MAX       = 23,
    parameter int MINSEC_MAX      = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] q_hours,
    input  logic [5:0] q_minutes,
    input  logic [5:0] q_seconds,
    output logic       hold,
    output logic       load,
    output logic [4:0] set_hours,
    output logic [5:0] set_minutes,
    output logic [5:0] set_seconds,
    output logic [1:0] field_sel
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, LOAD} state_t;
    state_t state, state_next;

    // Bit order everywhere: [0]=mode, [1]=inc, [2]=dec.
    logic [2:0]    raw, sync1, sync2, deb, deb_d, press;
    logic [CW-1:0] cnt [3];
    logic          mode_p, inc_p, dec_p;

    assign raw = {btn_dec, btn_inc, btn_mode};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Mode beats inc/dec; inc together with dec cancels out.
    assign press  = deb & ~deb_d;
    assign mode_p = press[0];
    assign inc_p  = press[1] & ~press[2] & ~press[0];
    assign dec_p  = press[2] & ~press[1] & ~press[0];

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] mx);
        wrap_inc = (v >= mx) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] mx);
        wrap_dec = (v == 6'd0 || v > mx) ? mx : v - 6'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (mode_p) state_next = SET_H;
            SET_H:   if (mode_p) state_next = SET_M;
            SET_M:   if (mode_p) state_next = SET_S;
            SET_S:   if (mode_p) state_next = LOAD;
            LOAD:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        hold      = 1'b0;
        load      = 1'b0;
        field_sel = 2'd0;
        case (state)
            SET_H:   begin hold = 1'b1; field_sel = 2'd1; end
            SET_M:   begin hold = 1'b1; field_sel = 2'd2; end
            SET_S:   begin hold = 1'b1; field_sel = 2'd3; end
            LOAD:    begin hold = 1'b1; load = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            set_hours   <= '0;
            set_minutes <= '0;
            set_seconds <= '0;
        end else if (state == RUN && mode_p) begin
            set_hours   <= q_hours;
            set_minutes <= q_minutes;
            set_seconds <= q_seconds;
        end else begin
            case (state)
                SET_H: begin
                    if (inc_p) set_hours <= 5'(wrap_inc({1'b0, set_hours}, 6'(HOURS_MAX)));
                    if (dec_p) set_hours <= 5'(wrap_dec({1'b0, set_hours}, 6'(HOURS_MAX)));
                end
                SET_M: begin
                    if (inc_p) set_minutes <= wrap_inc(set_minutes, 6'(MINSEC_MAX));
                    if (dec_p) set_minutes <= wrap_dec(set_minutes, 6'(MINSEC_MAX));
                end
                SET_S: begin
                    if (inc_p) set_seconds <= wrap_inc(set_seconds, 6'(MINSEC_MAX));
                    if (dec_p) set_seconds <= wrap_dec(set_seconds, 6'(MINSEC_MAX));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_time_set_ctrl.sv
// Directed bench for clk_time_set_ctrl with a short debounce window.
// A vector table of button presses with expected shadow/field outputs, plus hand sequences for timing, load and reset.
module tb_clk_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc, btn_dec;
    logic [4:0] q_hours;
    logic [5:0] q_minutes, q_seconds;
    logic       hold, load;
    logic [4:0] set_hours;
    logic [5:0] set_minutes, set_seconds;
    logic [1:0] field_sel;

    int checks   = 0;
    int errors   = 0;
    int load_cnt = 0;

    clk_time_set_ctrl #(.DEBOUNCE_CYCLES(4), .HOURS_MAX(23), .MINSEC_MAX(59)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .q_hours(q_hours), .q_minutes(q_minutes), .q_seconds(q_seconds),
        .hold(hold), .load(load),
        .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
        .field_sel(field_sel)
    );

    always #5 clk = ~clk;

    // mask bits: [0]=mode, [1]=inc, [2]=dec
    typedef struct {
        logic [2:0] mask;
        logic [4:0] qh;
        logic [5:0] qm, qs;
        logic [4:0] h;
        logic [5:0] m, s;
        logic [1:0] fs;
        logic       hold;
    } vec_t;

    vec_t vecs [20];

    task automatic tick();
        @(posedge clk);
        #1;
        if (load) load_cnt++;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic [2:0] m);
        btn_mode = m[0];
        btn_inc  = m[1];
        btn_dec  = m[2];
    endtask

    task automatic press(input logic [2:0] m);
        set_btns(m);
        repeat (8) tick();
        set_btns(3'b000);
        repeat (10) tick();
    endtask

    task automatic check_set(input string tag, input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s);
        check({tag, "_hours"},   8'(set_hours),   8'(h));
        check({tag, "_minutes"}, 8'(set_minutes), 8'(mi));
        check({tag, "_seconds"}, 8'(set_seconds), 8'(s));
    endtask

    function automatic vec_t mk(input logic [2:0] mask, input logic [4:0] qh, input logic [5:0] qm,
                                input logic [5:0] qs, input logic [4:0] h, input logic [5:0] m,
                                input logic [5:0] s, input logic [1:0] fs, input logic hd);
        vec_t v;
        v.mask = mask; v.qh = qh; v.qm = qm; v.qs = qs;
        v.h = h; v.m = m; v.s = s; v.fs = fs; v.hold = hd;
        return v;
    endfunction

    task automatic apply_vec(input int i);
        string tag;
        tag = $sformatf("vec%0d", i);
        q_hours   = vecs[i].qh;
        q_minutes = vecs[i].qm;
        q_seconds = vecs[i].qs;
        press(vecs[i].mask);
        check_set(tag, vecs[i].h, vecs[i].m, vecs[i].s);
        check({tag, "_field_sel"}, 8'(field_sel), 8'(vecs[i].fs));
        check({tag, "_hold"},      8'(hold),      8'(vecs[i].hold));
        check({tag, "_load"},      8'(load),      8'd0);
    endtask

    initial begin
        vecs[0]  = mk(3'b010, 12, 34, 56, 13, 34, 56, 1, 1);
        vecs[1]  = mk(3'b010, 12, 34, 56, 14, 34, 56, 1, 1);
        vecs[2]  = mk(3'b010, 12, 34, 56, 15, 34, 56, 1, 1);
        vecs[3]  = mk(3'b001, 12, 34, 56, 15, 34, 56, 2, 1);
        vecs[4]  = mk(3'b100, 12, 34, 56, 15, 33, 56, 2, 1);
        vecs[5]  = mk(3'b001, 12, 34, 56, 15, 33, 56, 3, 1);
        vecs[6]  = mk(3'b110, 12, 34, 56, 15, 33, 56, 3, 1);
        vecs[7]  = mk(3'b010, 23,  0,  0, 15, 33, 56, 0, 0);
        vecs[8]  = mk(3'b100, 23,  0,  0, 15, 33, 56, 0, 0);
        vecs[9]  = mk(3'b001, 23,  0,  0, 23,  0,  0, 1, 1);
        vecs[10] = mk(3'b010, 23,  0,  0,  0,  0,  0, 1, 1);
        vecs[11] = mk(3'b100, 23,  0,  0, 23,  0,  0, 1, 1);
        vecs[12] = mk(3'b001, 23,  0,  0, 23,  0,  0, 2, 1);
        vecs[13] = mk(3'b011, 23,  0,  0, 23,  0,  0, 3, 1);
        vecs[14] = mk(3'b100, 23,  0,  0, 23,  0, 59, 3, 1);
        vecs[15] = mk(3'b010, 23,  0,  0, 23,  0,  0, 3, 1);
        vecs[16] = mk(3'b001, 23,  0,  0, 23,  0,  0, 0, 0);
        vecs[17] = mk(3'b001,  5, 62,  7,  5, 62,  7, 1, 1);
        vecs[18] = mk(3'b001,  5, 62,  7,  5, 62,  7, 2, 1);
        vecs[19] = mk(3'b010,  5, 62,  7,  5,  0,  7, 2, 1);

        // Reset
        reset = 1'b0;
        set_btns(3'b000);
        q_hours = 12; q_minutes = 34; q_seconds = 56;
        repeat (3) tick();
        check("rst_hold", 8'(hold), 8'd0);
        check("rst_load", 8'(load), 8'd0);
        check("rst_field_sel", 8'(field_sel), 8'd0);
        check_set("rst", 0, 0, 0);
        reset = 1'b1;
        tick();

        // Glitches shorter than the debounce window
        set_btns(3'b001);
        repeat (3) tick();
        set_btns(3'b000);
        repeat (12) tick();
        check("glitch_mode_field_sel", 8'(field_sel), 8'd0);
        check("glitch_mode_hold", 8'(hold), 8'd0);
        set_btns(3'b010);
        repeat (3) tick();
        set_btns(3'b000);
        repeat (12) tick();
        check("glitch_inc_hours", 8'(set_hours), 8'd0);

        // Held mode button: SET_H exactly 7 cycles after the raw edge, single press
        set_btns(3'b001);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 6) check("latency_early_field_sel", 8'(field_sel), 8'd0);
            if (i == 7) begin
                check("latency_field_sel", 8'(field_sel), 8'd1);
                check("latency_hold", 8'(hold), 8'd1);
                check_set("capture", 12, 34, 56);
            end
        end
        set_btns(3'b000);
        repeat (10) tick();
        check("held_single_press", 8'(field_sel), 8'd1);

        for (int i = 0; i <= 6; i++) apply_vec(i);

        // SET_S + mode -> one-cycle LOAD, then RUN
        begin
            logic found;
            found = 1'b0;
            set_btns(3'b001);
            for (int i = 0; i < 12 && !found; i++) begin
                tick();
                if (load) found = 1'b1;
            end
            check("load_seen", 8'(found), 8'd1);
            if (found) begin
                check_set("load", 15, 33, 56);
                check("load_hold", 8'(hold), 8'd1);
                check("load_field_sel", 8'(field_sel), 8'd0);
                tick();
                check("post_load_load", 8'(load), 8'd0);
                check("post_load_hold", 8'(hold), 8'd0);
                check("post_load_field_sel", 8'(field_sel), 8'd0);
            end
            repeat (6) tick();
            set_btns(3'b000);
            repeat (10) tick();
            check("load_count_1", 8'(load_cnt), 8'd1);
        end

        for (int i = 7; i <= 19; i++) apply_vec(i);
        check("load_count_2", 8'(load_cnt), 8'd2);

        // Reset mid-edit (currently SET_M)
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_field_sel", 8'(field_sel), 8'd0);
        check("midrst_hold", 8'(hold), 8'd0);
        check("midrst_load", 8'(load), 8'd0);
        check_set("midrst", 0, 0, 0);
        repeat (5) tick();
        check("midrst_state_run", 8'(field_sel), 8'd0);
        check("midrst_no_load", 8'(load_cnt), 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
